dds_cmd_ctrl: RTL
=================

Name: dds_cmd_ctrl

Overview:
Command sequencer between spi_in and the DDS voice datapath. Consumes decoded SPI packets (8-bit cmd_word, 16-bit data_word, cmd_valid), writes per-voice shadow registers, and on COMMIT copies selected shadows to the active registers feeding the phase accumulators. Glitch-free, multi-voice-atomic retuning. Also drives gate and phase-reset controls and sticky status flags.

Parameters:
NUM_VOICES, 4, number of DDS voices (1..16)
FTW_WIDTH, 24, frequency tuning word width (17..32)
CMD_WIDTH, 8, command word width
DATA_WIDTH, 16, data word width

Ports:
sys_clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_word  in  CMD_WIDTH  opcode [7:4], voice index [3:0]; valid with cmd_valid
data_word  in  DATA_WIDTH  command payload
cmd_valid  in  1  single-cycle pulse, sys_clk domain
ftw_active  out  NUM_VOICES*FTW_WIDTH  active FTWs, voice v at [v*FTW_WIDTH +: FTW_WIDTH]
amp_active  out  NUM_VOICES*8  active amplitudes
wave_sel  out  NUM_VOICES*2  active waveform select
gate  out  NUM_VOICES  per-voice output enable
phase_rst  out  NUM_VOICES  one-cycle phase-accumulator clear pulses
update_strobe  out  1  one-cycle pulse at end of COMMIT
busy  out  1  high whenever state != IDLE
err_flag  out  1  sticky: illegal opcode or voice index >= NUM_VOICES
overrun  out  1  sticky: cmd_valid received while busy

Behaviour:
- Reset (async, rst_n=0): all shadow and active registers 0, gate 0, phase_rst 0, update_strobe 0, err_flag 0, overrun 0, state IDLE.
- FSM states: IDLE, EXEC, COPY, DONE.
- IDLE: on edge with cmd_valid=1, latch cmd_word/data_word, go to EXEC.
- EXEC (one cycle), by opcode, v = cmd[3:0]:
  0x0 NOP; 0x1 FTW_LO shadow_ftw[v][15:0]=data; 0x2 FTW_HI shadow_ftw[v][FTW_WIDTH-1:16]=data[FTW_WIDTH-17:0];
  0x3 AMP shadow_amp[v]=data[7:0]; 0x4 WAVE shadow_wave[v]=data[1:0];
  0x5 COMMIT mask=data[NUM_VOICES-1:0], voice index ignored, go COPY with i=0;
  0x6 GATE gate[v]=data[0] (immediate, no shadow); 0x7 PHRST phase_rst[v]=1 for exactly the next cycle;
  0xF CLEAR_STATUS clears err_flag and overrun; all other opcodes set err_flag, no register change.
  Opcodes 0x1-0x4, 0x6, 0x7 with v >= NUM_VOICES: set err_flag, no write. Non-COMMIT: return to IDLE.
- Latency: non-COMMIT effect visible 2 edges after the edge sampling cmd_valid.
- COPY: one voice per cycle, i=0..NUM_VOICES-1; if mask[i], active ftw/amp/wave[i] <= shadow[i]. After i=NUM_VOICES-1 go DONE.
- DONE: update_strobe=1 for one cycle, return to IDLE. COMMIT total: NUM_VOICES+2 edges after cmd_valid to strobe.
- COMMIT with mask=0: COPY still runs the full NUM_VOICES cycles, no active change, strobe still pulses.
- cmd_valid while busy: command dropped, overrun set; the in-flight operation completes unaffected.
- Shadow writes never alter active registers except via COPY. FTW_HI bits beyond FTW_WIDTH-17 ignored.
- Reset mid-COPY: all registers return to reset values immediately; partial copy is not preserved.

Optional Feature:
DDS_AUTO_COMMIT_EN: when defined, a successful FTW_HI write to voice v also copies shadow_ftw[v] (ftw only) to active in EXEC and pulses update_strobe on the following cycle; busy stays high for that cycle. When undefined, FTW_HI affects only the shadow and the active FTW changes solely via COMMIT.

Test Plan:
- Reset: drive rst_n=0 mid-run -> all outputs 0 asynchronously, busy=0.
- FTW_LO v1 data 0x4089, FTW_HI v1 data 0x0067, COMMIT data 0x0002 -> ftw_active voice1=0x674089, others 0, update_strobe 6 edges after COMMIT cmd_valid (NUM_VOICES=4).
- Shadow isolation: FTW_LO v0 0x1234 without COMMIT -> ftw_active voice0 stays 0; COMMIT mask 0x0 -> strobe pulses, still 0.
- Illegal: cmd 0x96 -> err_flag=1, no register change; cmd 0x15 (v=5) -> err_flag=1; cmd 0xF0 -> err_flag=0.
- Overrun: COMMIT then cmd_valid 0x23 on next cycle -> overrun=1, shadow_amp v3 unchanged, COMMIT completes.
- GATE v2 data 1 then PHRST v2 -> gate=0b0100; phase_rst=0b0100 for exactly one cycle.

Source files
------------

// File: rtl/dds_cmd_ctrl.sv
// dds_cmd_ctrl: command sequencer between the SPI decoder and the DDS voices.
// Writes per-voice shadow registers and moves them to the active registers
// on COMMIT, so several voices retune on the same cycle without glitches.
// Optional feature macro: DDS_AUTO_COMMIT_EN (FTW_HI also loads the active FTW).
//
// state | meaning
// IDLE  | waiting for cmd_valid
// EXEC  | decode and execute the latched command (one cycle)
// COPY  | shadow -> active copy, one voice per cycle, masked
// DONE  | update_strobe cycle, then back to IDLE
module dds_cmd_ctrl #(
    parameter int NUM_VOICES = 4,
    parameter int FTW_WIDTH  = 24,
    parameter int CMD_WIDTH  = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                            sys_clk,
    input  logic                            rst_n,
    input  logic [CMD_WIDTH-1:0]            cmd_word,
    input  logic [DATA_WIDTH-1:0]           data_word,
    input  logic                            cmd_valid,
    output logic [NUM_VOICES*FTW_WIDTH-1:0] ftw_active,
    output logic [NUM_VOICES*8-1:0]         amp_active,
    output logic [NUM_VOICES*2-1:0]         wave_sel,
    output logic [NUM_VOICES-1:0]           gate,
    output logic [NUM_VOICES-1:0]           phase_rst,
    output logic                            update_strobe,
    output logic                            busy,
    output logic                            err_flag,
    output logic                            overrun
);

    localparam int HI_WIDTH = FTW_WIDTH - 16;

    localparam logic [3:0] OP_FTW_LO = 4'h1;
    localparam logic [3:0] OP_FTW_HI = 4'h2;
    localparam logic [3:0] OP_AMP    = 4'h3;
    localparam logic [3:0] OP_WAVE   = 4'h4;
    localparam logic [3:0] OP_COMMIT = 4'h5;
    localparam logic [3:0] OP_GATE   = 4'h6;
    localparam logic [3:0] OP_PHRST  = 4'h7;
    localparam logic [3:0] OP_CLEAR  = 4'hF;

    localparam logic [3:0] LAST_IDX    = 4'(NUM_VOICES - 1);
    localparam logic [4:0] VOICE_LIMIT = 5'(NUM_VOICES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        COPY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, next_state;

    logic [CMD_WIDTH-1:0]  cmd_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [3:0]            copy_idx;

    logic [NUM_VOICES-1:0][FTW_WIDTH-1:0] shadow_ftw;
    logic [NUM_VOICES-1:0][FTW_WIDTH-1:0] active_ftw;
    logic [NUM_VOICES-1:0][7:0]           shadow_amp;
    logic [NUM_VOICES-1:0][7:0]           active_amp;
    logic [NUM_VOICES-1:0][1:0]           shadow_wave;
    logic [NUM_VOICES-1:0][1:0]           active_wave;

    logic [3:0] opcode;
    logic [3:0] vidx;
    logic       voice_ok;
    logic       voice_op;
    logic       op_illegal;
    logic       cmd_bad;

    assign opcode   = cmd_reg[7:4];
    assign vidx     = cmd_reg[3:0];
    assign voice_ok = ({1'b0, vidx} < VOICE_LIMIT);

    // Classify the latched opcode: voice-addressed, reserved, or rejected.
    always_comb begin
        voice_op   = 1'b0;
        op_illegal = 1'b0;
        case (opcode)
            OP_FTW_LO, OP_FTW_HI, OP_AMP, OP_WAVE, OP_GATE, OP_PHRST: voice_op = 1'b1;
            4'h0, OP_COMMIT, OP_CLEAR:                                 voice_op = 1'b0;
            default:                                                   op_illegal = 1'b1;
        endcase
        cmd_bad = op_illegal || (voice_op && !voice_ok);
    end

    // Sequencer state register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_valid) next_state = EXEC;
            end
            EXEC: begin
                next_state = IDLE;
                if (opcode == OP_COMMIT) begin
                    next_state = COPY;
                end
`ifdef DDS_AUTO_COMMIT_EN
                else if (opcode == OP_FTW_HI && voice_ok) begin
                    next_state = DONE;
                end
`endif
            end
            COPY: begin
                if (copy_idx == LAST_IDX) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Command latch, shadow/active register file, pulses and sticky status.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_reg       <= '0;
            data_reg      <= '0;
            copy_idx      <= '0;
            shadow_ftw    <= '0;
            active_ftw    <= '0;
            shadow_amp    <= '0;
            active_amp    <= '0;
            shadow_wave   <= '0;
            active_wave   <= '0;
            gate          <= '0;
            phase_rst     <= '0;
            update_strobe <= 1'b0;
            err_flag      <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            phase_rst     <= '0;
            update_strobe <= (next_state == DONE);

            if (state == IDLE && cmd_valid) begin
                cmd_reg  <= cmd_word;
                data_reg <= data_word;
            end

            case (state)
                EXEC: begin
                    copy_idx <= '0;
                    if (cmd_bad) err_flag <= 1'b1;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (vidx == 4'(i)) begin
                            case (opcode)
                                OP_FTW_LO: shadow_ftw[i][15:0] <= data_reg[15:0];
                                OP_FTW_HI: begin
                                    shadow_ftw[i][FTW_WIDTH-1:16] <= data_reg[HI_WIDTH-1:0];
`ifdef DDS_AUTO_COMMIT_EN
                                    active_ftw[i] <= {data_reg[HI_WIDTH-1:0], shadow_ftw[i][15:0]};
`endif
                                end
                                OP_AMP:    shadow_amp[i]  <= data_reg[7:0];
                                OP_WAVE:   shadow_wave[i] <= data_reg[1:0];
                                OP_GATE:   gate[i]        <= data_reg[0];
                                OP_PHRST:  phase_rst[i]   <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                    if (opcode == OP_CLEAR) begin
                        err_flag <= 1'b0;
                        overrun  <= 1'b0;
                    end
                end
                COPY: begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (copy_idx == 4'(i) && data_reg[i]) begin
                            active_ftw[i]  <= shadow_ftw[i];
                            active_amp[i]  <= shadow_amp[i];
                            active_wave[i] <= shadow_wave[i];
                        end
                    end
                    copy_idx <= copy_idx + 4'd1;
                end
                default: ;
            endcase

            // A command arriving while busy is dropped; flag it after any clear.
            if (cmd_valid && state != IDLE) overrun <= 1'b1;
        end
    end

    assign ftw_active = active_ftw;
    assign amp_active = active_amp;
    assign wave_sel   = active_wave;
    assign busy       = (state != IDLE);

endmodule
